// File: rtl/io_bank_filtered_pkg.sv
// Shared definitions for the filtered pad bank: pad tristate encoding and
// default filter/synchroniser sizing.
package io_bank_filtered_pkg;

  typedef enum logic {
    PAD_DRIVE = 1'b0,
    PAD_HIZ   = 1'b1
  } pad_dir_e;

  localparam int unsigned DEF_FILTER_BITS = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/io_bank_filtered_channel.sv
// One input channel: synchroniser chain, glitch-filter counter, filtered
// state and single-cycle raw edge pulses.
module io_filter_channel
  import io_bank_filtered_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_BITS = DEF_FILTER_BITS,
  parameter logic        RESET_BIT   = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_pad,
  input  logic [FILTER_BITS-1:0] i_filter_len,
  output logic                   o_stable,
  output logic                   o_raw_rise,
  output logic                   o_raw_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FILTER_BITS-1:0] r_cnt;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync   <= {SYNC_STAGES{RESET_BIT}};
      r_stable <= RESET_BIT;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_synced == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_filter_len) begin
        // >= so a length lowered mid-count accepts at once; cnt stays <= L, never wraps
        r_stable <= w_synced;
        r_cnt    <= '0;
        r_rise   <= w_synced;
        r_fall   <= ~w_synced;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable   = r_stable;
  assign o_raw_rise = r_rise;
  assign o_raw_fall = r_fall;

endmodule

// File: rtl/io_bank_filtered.sv
// WIDTH-channel bidirectional pad bank: registered drive/tristate towards the
// pad cells, synchronised and glitch-filtered inputs with edge pulses.
module io_bank_filtered
  import io_bank_filtered_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned      FILTER_BITS = DEF_FILTER_BITS,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       pad_i,
  output logic [WIDTH-1:0]       pad_o,
  output logic [WIDTH-1:0]       pad_t,
  input  logic [WIDTH-1:0]       out_data,
  input  logic [WIDTH-1:0]       out_enable,
  input  logic [FILTER_BITS-1:0] cfg_filter_len,
  input  logic [WIDTH-1:0]       cfg_invert,
  output logic [WIDTH-1:0]       in_data,
  output logic [WIDTH-1:0]       in_rise,
  output logic [WIDTH-1:0]       in_fall
);

  logic [WIDTH-1:0] r_pad_o;
  logic [WIDTH-1:0] r_pad_t;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_raw_rise;
  logic [WIDTH-1:0] w_raw_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pad_o <= '0;
      r_pad_t <= {WIDTH{PAD_HIZ}};
    end else begin
      r_pad_o <= out_data;
      r_pad_t <= ~out_enable;
    end
  end

  assign pad_o = r_pad_o;
  assign pad_t = r_pad_t;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    io_filter_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_BITS (FILTER_BITS),
      .RESET_BIT   (RESET_VAL[g])
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .i_pad        (pad_i[g]),
      .i_filter_len (cfg_filter_len),
      .o_stable     (w_stable[g]),
      .o_raw_rise   (w_raw_rise[g]),
      .o_raw_fall   (w_raw_fall[g])
    );
  end

  // Inversion is applied after the filter so toggling it never creates a pulse.
  assign in_data = w_stable ^ cfg_invert;
  assign in_rise = (w_raw_rise & ~cfg_invert) | (w_raw_fall & cfg_invert);
  assign in_fall = (w_raw_fall & ~cfg_invert) | (w_raw_rise & cfg_invert);

endmodule

// File: tb/tb_io_bank_filtered.sv
// Self-checking bench for io_bank_filtered: table-driven output path, directed
// filter corner cases and randomized traffic against a behavioural model.
module tb_io_bank_filtered;

  localparam int unsigned      W  = 8;
  localparam int unsigned      SS = 2;
  localparam int unsigned      FB = 4;
  localparam logic [W-1:0]     RV = '0;

  logic          clk;
  logic          reset;
  logic [W-1:0]  pad_i, pad_o, pad_t, out_data, out_enable;
  logic [FB-1:0] cfg_filter_len;
  logic [W-1:0]  cfg_invert, in_data, in_rise, in_fall;

  io_bank_filtered #(
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .FILTER_BITS (FB),
    .RESET_VAL   (RV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pad_i          (pad_i),
    .pad_o          (pad_o),
    .pad_t          (pad_t),
    .out_data       (out_data),
    .out_enable     (out_enable),
    .cfg_filter_len (cfg_filter_len),
    .cfg_invert     (cfg_invert),
    .in_data        (in_data),
    .in_rise        (in_rise),
    .in_fall        (in_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: delay line of sampled pad values, accepted state, and per-channel
  // length of the current run of samples disagreeing with the accepted state.
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_stable, m_rise, m_fall, m_pad_o, m_pad_t;
  int unsigned  m_run[W];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    m_rise = '0;
    m_fall = '0;
    if (reset) begin
      m_hist.delete();
      for (int i = 0; i < int'(SS); i++) m_hist.push_back(RV);
      m_stable = RV;
      for (int i = 0; i < int'(W); i++) m_run[i] = 0;
      m_pad_o = '0;
      m_pad_t = '1;
    end else begin
      s = m_hist.pop_front();
      m_hist.push_back(pad_i);
      m_pad_o = out_data;
      m_pad_t = ~out_enable;
      for (int i = 0; i < int'(W); i++) begin
        if (s[i] == m_stable[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] >= int'(cfg_filter_len) + 1) begin
            m_stable[i] = s[i];
            m_rise[i]   = s[i];
            m_fall[i]   = ~s[i];
            m_run[i]    = 0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model pad_o",   pad_o,   m_pad_o);
    chk("model pad_t",   pad_t,   m_pad_t);
    chk("model in_data", in_data, m_stable ^ cfg_invert);
    chk("model in_rise", in_rise, (m_rise & ~cfg_invert) | (m_fall & cfg_invert));
    chk("model in_fall", in_fall, (m_fall & ~cfg_invert) | (m_rise & cfg_invert));
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] od;
    logic [W-1:0] oe;
    logic [W-1:0] exp_po;
    logic [W-1:0] exp_pt;
  } ovec_t;

  ovec_t tbl[$];

  initial begin
    reset = 1'b1; pad_i = '0; out_data = '0; out_enable = '0;
    cfg_filter_len = '0; cfg_invert = '0;
    for (int i = 0; i < int'(SS); i++) m_hist.push_back(RV);

    // Reset and output path
    tbl.push_back('{1'b1, 8'hA5, 8'hFF, 8'h00, 8'hFF});
    tbl.push_back('{1'b1, 8'hA5, 8'hFF, 8'h00, 8'hFF});
    tbl.push_back('{1'b1, 8'hA5, 8'hFF, 8'h00, 8'hFF});
    tbl.push_back('{1'b0, 8'hA5, 8'hFF, 8'hA5, 8'h00});
    tbl.push_back('{1'b0, 8'h3C, 8'h0F, 8'h3C, 8'hF0});
    tbl.push_back('{1'b0, 8'hFF, 8'h00, 8'hFF, 8'hFF});
    tbl.push_back('{1'b0, 8'h00, 8'hAA, 8'h00, 8'h55});
    foreach (tbl[i]) begin
      reset = tbl[i].rst; out_data = tbl[i].od; out_enable = tbl[i].oe;
      tick();
      chk("tbl pad_o", pad_o, tbl[i].exp_po);
      chk("tbl pad_t", pad_t, tbl[i].exp_pt);
      if (tbl[i].rst) begin
        chk("tbl rst in_data", in_data, '0);
        chk("tbl rst edges", in_rise | in_fall, '0);
      end
    end

    // Latency with L=3
    cfg_filter_len = 4'd3;
    repeat (3) tick();
    pad_i = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk1("lat in_data0", in_data[0], k >= 6);
      chk1("lat in_rise0", in_rise[0], k == 6);
    end

    // Glitch of 3 samples rejected, 4 accepted
    pad_i[1] = 1'b1;
    repeat (3) tick();
    pad_i[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk1("glitch in_data1", in_data[1], 1'b0);
      chk1("glitch edges1", in_rise[1] | in_fall[1], 1'b0);
    end
    pad_i[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) pad_i[1] = 1'b0;
      tick();
      chk1("pulse4 in_data1", in_data[1], k >= 6 && k < 10);
      chk1("pulse4 in_rise1", in_rise[1], k == 6);
      chk1("pulse4 in_fall1", in_fall[1], k == 10);
    end

    // Bypass with inversion, then invert toggle alone
    cfg_filter_len = 4'd0;
    cfg_invert = 8'h04;
    #1;
    chk1("inv pre in_data2", in_data[2], 1'b1);
    tick();
    pad_i[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk1("byp in_data2", in_data[2], k < 3);
      chk1("byp in_fall2", in_fall[2], k == 3);
      chk1("byp in_rise2", in_rise[2], 1'b0);
    end
    cfg_invert[2] = 1'b0;
    #1;
    chk1("invtog in_data2", in_data[2], 1'b1);
    chk1("invtog edges2", in_rise[2] | in_fall[2], 1'b0);
    repeat (3) tick();

    // Reset mid-count restarts the filter
    cfg_filter_len = 4'd7;
    pad_i[3] = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("midrst edges", in_rise | in_fall, '0);
    chk("midrst in_data", in_data, RV ^ cfg_invert);
    reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk1("midrst in_data3", in_data[3], k >= 10);
      chk1("midrst in_rise3", in_rise[3], k == 10);
    end

    // All channels together, L shrunk from 15 to 2 with count at 9
    pad_i = '0;
    cfg_filter_len = 4'd0;
    repeat (6) tick();
    cfg_filter_len = 4'd15;
    pad_i = '1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 12) cfg_filter_len = 4'd2;
      tick();
      chk("shrink in_data", in_data, (k >= 12) ? 8'hFF : 8'h00);
      chk("shrink in_rise", in_rise, (k == 12) ? 8'hFF : 8'h00);
    end

    // Randomized traffic
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cfg_filter_len = 4'd2;
    for (int n = 0; n < 1500; n++) begin
      pad_i = pad_i ^ W'($urandom() & $urandom());
      out_data = W'($urandom());
      out_enable = W'($urandom());
      if ($urandom_range(0, 19) == 0) cfg_invert = W'($urandom());
      if ($urandom_range(0, 29) == 0) cfg_filter_len = FB'($urandom_range(0, 4));
      reset = ($urandom_range(0, 99) == 0);
      tick();
      n_cmp++;
      if ((in_rise & in_fall) !== '0) begin
        n_fail++;
        $display("FAIL rand rise&fall @%0t: got %h expected 00", $time, in_rise & in_fall);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
